// File: rtl/sonar_pkg.sv
// Shared sonar front-end definitions: default channel geometry and a helper
// that pulls one channel's word out of a packed multi-channel bus.
package sonar_pkg;
  localparam int DEF_CH   = 4;
  localparam int DEF_CH_W = 2;
  localparam int MAX_N    = 64;
  localparam int MAX_BUS  = MAX_N * 16;

  // Caller truncates the result to its own word width.
  function automatic logic [MAX_N-1:0] get_ch(input logic [MAX_BUS-1:0] bus,
                                              input int k, input int n);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (k * n);
    return sh[MAX_N-1:0];
  endfunction
endpackage

// File: rtl/mul_trunc.sv
// Unsigned N x N multiplier keeping only the low N bits of the product.
module mul_trunc #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import sonar_pkg::*;
#(
  parameter int CH   = DEF_CH,
  parameter int CH_W = $clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic            en,
  input  logic [CH_W-1:0] ptr,
  output logic [CH-1:0]   grant,
  output logic [CH_W-1:0] gidx,
  output logic            any
);
  logic [CH_W-1:0] idx;

  // CH is a power of two, so the index add wraps modulo CH for free.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = ptr + CH_W'(i);
      if (en && !any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// Shares one gain multiplier among CH requesters with round-robin grant and a
// single backpressured output register tagged with the channel index.
module mult_share_arb
  import sonar_pkg::*;
#(
  parameter int N    = 32,
  parameter int CH   = DEF_CH,
  parameter int CH_W = DEF_CH_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   req_valid_i,
  input  logic [CH*N-1:0] req_data_i,
  output logic [CH-1:0]   req_ready_o,
  input  logic [CH*N-1:0] gain_i,
  output logic            out_valid_o,
  output logic [N-1:0]    out_data_o,
  output logic [CH_W-1:0] out_ch_o,
  input  logic            out_ready_i
);
  logic [CH-1:0][N-1:0] data_lane, gain_lane;
  logic [CH_W-1:0]      ptr, gidx;
  logic [CH-1:0]        grant;
  logic                 any, free, en;
  logic [N-1:0]         prod;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign data_lane[k] = N'(get_ch(MAX_BUS'(req_data_i), k, N));
    assign gain_lane[k] = N'(get_ch(MAX_BUS'(gain_i), k, N));
  end

  assign free = !out_valid_o || out_ready_i;
  // Holding ready low during reset keeps requesters from seeing an accept.
  assign en   = free && !rst;

  rr_arbiter #(.CH(CH), .CH_W(CH_W)) u_arb (
    .req   (req_valid_i),
    .en    (en),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  assign req_ready_o = grant;

  mul_trunc #(.N(N)) u_mul (
    .a (data_lane[gidx]),
    .b (gain_lane[gidx]),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      ptr         <= '0;
    end else if (free) begin
      out_valid_o <= any;
      if (any) begin
        out_data_o <= prod;
        out_ch_o   <= gidx;
        ptr        <= gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized and directed bench for mult_share_arb against a queue-free
// behavioural model of the round-robin multiply-and-tag behaviour.
module tb_mult_share_arb;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic [127:0] gain = '0;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_valid = 0;
  logic [31:0] m_data = '0;
  int          m_ch = 0;
  int          m_ptr = 0;

  mult_share_arb #(.N(32), .CH(4), .CH_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .gain_i      (gain),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(logic [3:0] v, int p);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant(req_valid, m_ptr);
    if (rst || !(!m_valid || out_ready) || g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic set_ch(int k, logic [31:0] d, logic [31:0] g);
    req_data[k*32 +: 32] = d;
    gain[k*32 +: 32]     = g;
  endtask

  // Advance one clock; model's next state is computed from pre-edge inputs.
  task automatic tick();
    int g;
    logic [63:0] pr;
    bit nv; logic [31:0] nd; int nc, np;
    nv = m_valid; nd = m_data; nc = m_ch; np = m_ptr;
    g = exp_grant(req_valid, m_ptr);
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        pr = {32'd0, req_data[g*32 +: 32]} * {32'd0, gain[g*32 +: 32]};
        nv = 1; nd = pr[31:0]; nc = g; np = (g + 1) % 4;
      end else nv = 0;
    end
    @(posedge clk); #1;
    m_valid = nv; m_data = nd; m_ch = nc; m_ptr = np;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_ch(k, 32'(k + 1), 32'd10);
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0d want=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
    #1 rst = 1'b0;
    model_reset();
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'd10)
      begin failures++; $display("FAIL reset_first_grant got v=%b ch=%0d d=%0d want v=1 ch=0 d=10", out_valid, out_ch, out_data); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    set_ch(2, 32'd7, 32'd3);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd21 || out_ch !== 2'd2)
      begin failures++; $display("FAIL single got v=%b d=%0d ch=%0d want v=1 d=21 ch=2", out_valid, out_data, out_ch); end
    req_valid = 4'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd21 || out_ch !== 2'd2)
      begin failures++; $display("FAIL single_drain got v=%b d=%0d ch=%0d want v=0 d=21 ch=2", out_valid, out_data, out_ch); end
  endtask

  task automatic test_wrap();
    req_valid = 4'b0001;
    set_ch(0, 32'h8000_0000, 32'd2);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd0 || out_ch !== 2'd0)
      begin failures++; $display("FAIL wrap got v=%b d=%h ch=%0d want v=1 d=0 ch=0", out_valid, out_data, out_ch); end
    set_ch(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    checks++; if (out_data !== 32'd1)
      begin failures++; $display("FAIL wrap_ones got=%h want=00000001", out_data); end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int seq1[6] = '{0, 1, 2, 3, 0, 1};
    int seq2[6] = '{2, 3, 0, 2, 3, 0};
    rst = 1'b1; #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) set_ch(k, 32'(100 + k), 32'(k + 2));
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || int'(out_ch) != seq1[i])
        begin failures++; $display("FAIL rr_all[%0d] got v=%b ch=%0d want v=1 ch=%0d", i, out_valid, out_ch, seq1[i]); end
    end
    req_valid = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || int'(out_ch) != seq2[i] || out_data !== m_data)
        begin failures++; $display("FAIL rr_drop1[%0d] got ch=%0d d=%0d want ch=%0d d=%0d", i, out_ch, out_data, seq2[i], m_data); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_d; logic [1:0] held_c;
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    held_d = out_data; held_c = out_ch;
    checks++; if (out_data !== m_data || int'(out_ch) != m_ch)
      begin failures++; $display("FAIL bp_load got d=%0d ch=%0d want d=%0d ch=%0d", out_data, out_ch, m_data, m_ch); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) gain[k*32 +: 32] = $urandom;
      #1;
      checks++; if (req_ready !== 4'b0)
        begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, req_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_ch !== held_c)
        begin failures++; $display("FAIL bp_hold[%0d] got v=%b d=%0d ch=%0d want v=1 d=%0d ch=%0d", i, out_valid, out_data, out_ch, held_d, held_c); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'(held_c + 2'd1) || out_data !== m_data)
      begin failures++; $display("FAIL bp_release got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d", out_valid, out_ch, out_data, 2'(held_c + 2'd1), m_data); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    req_valid = 4'b0010;
    set_ch(1, 32'd5, 32'd5);
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1)
      begin failures++; $display("FAIL mrst_pre got v=%b ch=%0d want v=1 ch=1", out_valid, out_ch); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || req_ready !== 4'b0)
      begin failures++; $display("FAIL mrst_async got v=%b d=%0d rdy=%b want v=0 d=0 rdy=0000", out_valid, out_data, req_ready); end
    #1 rst = 1'b0;
    model_reset();
    req_valid = 4'hF;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0)
      begin failures++; $display("FAIL mrst_grant got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch); end
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      for (int k = 0; k < 4; k++) set_ch(k, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      checks++; if (req_ready !== er)
        begin failures++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, req_ready, er); end
      tick();
      checks++; if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch)
        begin failures++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
